// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage: holds up to two instructions (head + skid) between data memory and register-file write.
// Latency: an item accepted at edge N is on the *_out ports during cycle N+1 when it loads straight into head.
// Backpressure: in_ready is registered and drops only while both entries are held, so no accepted item is ever lost.
module mem_wb_skid #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  input  logic            memtoreg_in,
  input  logic            regwrite_in,
  input  logic [REGW-1:0] dst_in,
  input  logic [XLEN-1:0] dmemrd_in,
  input  logic [XLEN-1:0] aluresult_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            memtoreg_out,
  output logic            regwrite_out,
  output logic [REGW-1:0] dst_out,
  output logic [XLEN-1:0] dmemrd_out,
  output logic [XLEN-1:0] aluresult_out,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_we,
  output logic [1:0]      occupancy
);

  typedef struct packed {
    logic            memtoreg;
    logic            regwrite;
    logic [REGW-1:0] dst;
    logic [XLEN-1:0] dmemrd;
    logic [XLEN-1:0] aluresult;
  } ent_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;
  ent_t   head, skid, in_ent;
  logic   in_ready_q;
  logic   acc, deq;
  logic   ld_head_in, ld_head_skid, ld_skid;

  assign in_ent = '{memtoreg:  memtoreg_in,
                    regwrite:  regwrite_in,
                    dst:       dst_in,
                    dmemrd:    dmemrd_in,
                    aluresult: aluresult_in};

  assign in_ready  = in_ready_q;
  assign out_valid = (state != S_EMPTY);
  assign acc       = in_valid & in_ready_q;
  assign deq       = out_valid & out_ready;

  // Next-state and load selects; flush overrides any accept/dequeue in the same cycle.
  always_comb begin
    state_nxt    = state;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (acc) begin
            state_nxt  = S_ONE;
            ld_head_in = 1'b1;
          end
        end
        S_ONE: begin
          if (acc && !deq) begin
            state_nxt = S_FULL;
            ld_skid   = 1'b1;
          end else if (acc && deq) begin
            ld_head_in = 1'b1;
          end else if (deq) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a dequeue can happen.
          if (deq) begin
            state_nxt    = S_ONE;
            ld_head_skid = 1'b1;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  // State, registered ready, head and skid storage; flush clears only the control bits of head.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_EMPTY;
      in_ready_q <= 1'b1;
      head       <= '0;
      skid       <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != S_FULL);
      if (flush) begin
        head.memtoreg <= 1'b0;
        head.regwrite <= 1'b0;
      end else if (ld_head_in) begin
        head <= in_ent;
      end else if (ld_head_skid) begin
        head <= skid;
      end
      if (ld_skid) begin
        skid <= in_ent;
      end
    end
  end

  assign memtoreg_out  = head.memtoreg;
  assign regwrite_out  = head.regwrite;
  assign dst_out       = head.dst;
  assign dmemrd_out    = head.dmemrd;
  assign aluresult_out = head.aluresult;

  assign wb_data   = head.memtoreg ? head.dmemrd : head.aluresult;
  // Register x0 is hardwired to zero, so it never receives a write enable.
  assign wb_we     = deq & head.regwrite & (head.dst != '0);
  assign occupancy = (state == S_FULL) ? 2'd2 : (state == S_ONE) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;
  localparam int XLEN = 64;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            flush = 1'b0;
  logic            memtoreg_in = 1'b0;
  logic            regwrite_in = 1'b0;
  logic [REGW-1:0] dst_in = '0;
  logic [XLEN-1:0] dmemrd_in = '0;
  logic [XLEN-1:0] aluresult_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            memtoreg_out;
  logic            regwrite_out;
  logic [REGW-1:0] dst_out;
  logic [XLEN-1:0] dmemrd_out;
  logic [XLEN-1:0] aluresult_out;
  logic [XLEN-1:0] wb_data;
  logic            wb_we;
  logic [1:0]      occupancy;

  mem_wb_skid #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .dst_in(dst_in),
    .dmemrd_in(dmemrd_in), .aluresult_in(aluresult_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .memtoreg_out(memtoreg_out), .regwrite_out(regwrite_out), .dst_out(dst_out),
    .dmemrd_out(dmemrd_out), .aluresult_out(aluresult_out),
    .wb_data(wb_data), .wb_we(wb_we), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic            m;
    logic            r;
    logic [REGW-1:0] d;
    logic [XLEN-1:0] dm;
    logic [XLEN-1:0] al;
  } ent_t;

  // Reference model: an ordered list of instructions held by the stage, at most two deep.
  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   armed = 1'b0;
  int   clr   = 0;   // 0: none, 1: flushed since last load, 2: reset since last load

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor compares DUT outputs to the model head, then advances the model by the coming edge.
  always @(negedge clk) begin
    ent_t h, e;
    bit   acc_m, deq_m;
    if (armed) begin
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        h = q[0];
        chk("memtoreg_out", 64'(memtoreg_out), 64'(h.m));
        chk("regwrite_out", 64'(regwrite_out), 64'(h.r));
        chk("dst_out", 64'(dst_out), 64'(h.d));
        chk("dmemrd_out", dmemrd_out, h.dm);
        chk("aluresult_out", aluresult_out, h.al);
        chk("wb_data", wb_data, h.m ? h.dm : h.al);
        chk("wb_we", 64'(wb_we), 64'(out_ready && h.r && (h.d != 0)));
      end else begin
        chk("wb_we_idle", 64'(wb_we), 64'd0);
        if (clr != 0) begin
          chk("memtoreg_out_clr", 64'(memtoreg_out), 64'd0);
          chk("regwrite_out_clr", 64'(regwrite_out), 64'd0);
        end
        if (clr == 2) begin
          chk("dst_out_rst", 64'(dst_out), 64'd0);
          chk("dmemrd_out_rst", dmemrd_out, 64'd0);
          chk("aluresult_out_rst", aluresult_out, 64'd0);
        end
      end
    end
    e = '{m: memtoreg_in, r: regwrite_in, d: dst_in, dm: dmemrd_in, al: aluresult_in};
    if (rst) begin
      q.delete();
      clr   = 2;
      armed = 1'b1;
    end else if (armed) begin
      if (flush) begin
        q.delete();
        clr = 1;
      end else begin
        acc_m = in_valid && (q.size() < 2);
        deq_m = (q.size() > 0) && out_ready;
        if (deq_m) void'(q.pop_front());
        if (acc_m) begin
          q.push_back(e);
          clr = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic m, input logic r, input logic [REGW-1:0] d,
                        input logic [XLEN-1:0] dm, input logic [XLEN-1:0] al);
    memtoreg_in  = m;
    regwrite_in  = r;
    dst_in       = d;
    dmemrd_in    = dm;
    aluresult_in = al;
  endtask

  // Holds in_valid until the stage accepts (bounded), then drops it.
  task automatic wait_acc();
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1 within 50 cycles", in_ready);
    end
  endtask

  task automatic send(input logic m, input logic r, input logic [REGW-1:0] d,
                      input logic [XLEN-1:0] dm, input logic [XLEN-1:0] al);
    set_in(m, r, d, dm, al);
    in_valid = 1'b1;
    wait_acc();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset(2);
    step();

    // Streaming at full rate.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_in(1'b0, 1'b1, 5'd5, 64'h0, 64'(i));
      step();
    end
    in_valid = 1'b0;
    repeat (2) step();

    // Back-pressure: A and B fill the stage, C waits, then drain.
    out_ready = 1'b0;
    send(1'b0, 1'b1, 5'd7, 64'h0, 64'hA);
    send(1'b0, 1'b1, 5'd7, 64'h0, 64'hB);
    set_in(1'b0, 1'b1, 5'd7, 64'h0, 64'hC);
    in_valid = 1'b1;
    repeat (3) step();
    out_ready = 1'b1;
    wait_acc();
    repeat (4) step();

    // Load writeback and the x0 guard.
    send(1'b1, 1'b1, 5'd3, 64'hFFFF_FFFF_8000_0000, 64'h1000);
    send(1'b0, 1'b1, 5'd0, 64'h0, 64'h55);
    repeat (2) step();

    // Flush while full with a simultaneous valid input.
    out_ready = 1'b0;
    send(1'b1, 1'b1, 5'd9, 64'h21, 64'h121);
    send(1'b0, 1'b1, 5'd10, 64'h22, 64'h122);
    set_in(1'b1, 1'b1, 5'd11, 64'h77, 64'h77);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Reset in the middle of a stalled full stage.
    out_ready = 1'b0;
    send(1'b0, 1'b1, 5'd12, 64'h31, 64'h131);
    send(1'b1, 1'b1, 5'd13, 64'h32, 64'h132);
    set_in(1'b1, 1'b1, 5'd14, 64'h33, 64'h133);
    in_valid = 1'b1;
    flush    = 1'b1;
    do_reset(1);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    send(1'b0, 1'b1, 5'd6, 64'h0, 64'h9);
    repeat (2) step();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      set_in(1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)),
             {$urandom, $urandom}, {$urandom, $urandom});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
